piezo_alert_arb: RTL and testbench

Alert arbiter and scheduler for the Segway piezo tone path. It watches the three alert conditions `too_fast`, `batt_low` and `en_steer`. It decides which tune the downstream tone player performs and when, enforcing priority, preemption and the 3 s repeat interval. It sits between the balance/steer/battery monitors and the tone player, and uses a start/busy/done/abort handshake.

---
 rtl/piezo_alert_arb_pkg.sv | 37 +++
 rtl/piezo_alert_arb_if.sv | 25 ++
 rtl/piezo_alert_arb_repeat_tmr.sv | 29 ++
 rtl/piezo_alert_arb.sv | 121 ++++++++++++
 tb/tb_piezo_alert_arb.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/piezo_alert_arb_pkg.sv
// Shared types and constants for the piezo alert path (arbiter and tone player).
// The arbiter's optional statistics counters are enabled with PIEZO_ARB_STATS_EN.
package piezo_pkg;

    typedef enum logic [1:0] {
        TUNE_NONE  = 2'd0,
        TUNE_STEER = 2'd1,
        TUNE_BATT  = 2'd2,
        TUNE_FAST  = 2'd3
    } tune_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int unsigned TMR_W          = 28;
    localparam int unsigned REPEAT_CYC_DEF = 150_000_000;
    localparam int unsigned FAST_SIM_INC   = 64;
    localparam int unsigned CNT_W          = 8;

    // Note half-periods in 50 MHz clocks, shared with the tone player.
    localparam int unsigned HP_G6 = 15_944;
    localparam int unsigned HP_C7 = 11_945;
    localparam int unsigned HP_E7 = 9_480;
    localparam int unsigned HP_G7 = 7_972;

    localparam int unsigned DUR_2_22 = 1 << 22;
    localparam int unsigned DUR_2_23 = 1 << 23;
    localparam int unsigned DUR_2_24 = 1 << 24;

    function automatic logic [TMR_W-1:0] tmr_step(input bit fast);
        return fast ? TMR_W'(FAST_SIM_INC) : TMR_W'(1);
    endfunction

endpackage

// File: rtl/piezo_alert_arb_if.sv
// Alert and tone-player handshake bundle: monitors/player on one side, arbiter on the other.
interface piezo_alert_arb_if;
    import piezo_pkg::*;

    logic  too_fast;
    logic  batt_low;
    logic  en_steer;
    logic  tune_busy;
    logic  tune_done;
    logic  tune_start;
    tune_t tune_sel;
    logic  tune_abort;
    logic  active;

    modport master (
        input  too_fast, batt_low, en_steer, tune_busy, tune_done,
        output tune_start, tune_sel, tune_abort, active
    );

    modport slave (
        output too_fast, batt_low, en_steer, tune_busy, tune_done,
        input  tune_start, tune_sel, tune_abort, active
    );

endinterface

// File: rtl/piezo_alert_arb_repeat_tmr.sv
// Saturating repeat-interval down-counter; rpt_done while the count sits at zero.
module repeat_tmr
    import piezo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] rpt_cyc,
    input  logic [TMR_W-1:0] inc,
    output logic             rpt_done
);

    logic [TMR_W-1:0] tmr;

    // Load beats decrement; a remainder smaller than one step snaps to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr <= '0;
        else if (load)
            tmr <= rpt_cyc;
        else if (tmr < inc)
            tmr <= '0;
        else
            tmr <= tmr - inc;
    end

    assign rpt_done = (tmr == '0);

endmodule

// File: rtl/piezo_alert_arb.sv
// Piezo alert arbiter: picks fast/battery/steer tunes by priority, preempts on too_fast,
// spaces battery/steer repeats. Define PIEZO_ARB_STATS_EN to add per-tune start counters.
module piezo_alert_arb
    import piezo_pkg::*;
#(
    parameter bit          fast_sim   = 1'b1,
    parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    piezo_alert_arb_if.master  bus
`ifdef PIEZO_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   cnt_fast,
    output logic [CNT_W-1:0]   cnt_batt,
    output logic [CNT_W-1:0]   cnt_steer
`endif
);

    localparam logic [TMR_W-1:0] RPT_VAL = TMR_W'(REPEAT_CYC);
    localparam logic [TMR_W-1:0] INC_VAL = tmr_step(fast_sim);

    arb_state_t state;
    logic       start_q;
    logic       abort_q;
    tune_t      sel_q;
    logic       active_q;
    logic       rpt_done;
    logic       load_rpt;

    // Only battery/steer starts reload the interval; a fast tune leaves it alone.
    always_comb begin
        load_rpt = (state == ST_IDLE) && !bus.too_fast && rpt_done &&
                   (bus.batt_low || bus.en_steer);
    end

    repeat_tmr u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_rpt),
        .rpt_cyc  (RPT_VAL),
        .inc      (INC_VAL),
        .rpt_done (rpt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            sel_q    <= TUNE_NONE;
            active_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.too_fast) begin
                        start_q  <= 1'b1;
                        sel_q    <= TUNE_FAST;
                        active_q <= 1'b1;
                        state    <= ST_PLAY;
                    end else if (load_rpt) begin
                        start_q  <= 1'b1;
                        sel_q    <= bus.batt_low ? TUNE_BATT : TUNE_STEER;
                        active_q <= 1'b1;
                        state    <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // A normal completion in the same cycle as too_fast wins; IDLE then serves it.
                    if (bus.tune_done) begin
                        sel_q    <= TUNE_NONE;
                        active_q <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (bus.too_fast && sel_q != TUNE_FAST) begin
                        abort_q <= 1'b1;
                        state   <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    if (!bus.tune_busy) begin
                        sel_q    <= TUNE_NONE;
                        active_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    sel_q    <= TUNE_NONE;
                    active_q <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tune_start = start_q;
    assign bus.tune_abort = abort_q;
    assign bus.tune_sel   = sel_q;
    assign bus.active     = active_q;

`ifdef PIEZO_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_fast  <= '0;
            cnt_batt  <= '0;
            cnt_steer <= '0;
        end else if (start_q) begin
            unique case (sel_q)
                TUNE_FAST:  if (cnt_fast  != CNT_MAX) cnt_fast  <= cnt_fast  + 1'b1;
                TUNE_BATT:  if (cnt_batt  != CNT_MAX) cnt_batt  <= cnt_batt  + 1'b1;
                TUNE_STEER: if (cnt_steer != CNT_MAX) cnt_steer <= cnt_steer + 1'b1;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_piezo_alert_arb.sv
// Bench for piezo_alert_arb: directed scenarios plus randomized alerts against a tune-level model.
module tb_piezo_alert_arb;
    import piezo_pkg::*;

    localparam int RPT = 650;
    localparam int INC = 64;
    localparam int K   = (RPT + INC - 1) / INC;  // edges from a load until the interval has expired

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piezo_alert_arb_if bus ();

`ifdef PIEZO_ARB_STATS_EN
    logic [7:0] cnt_fast, cnt_batt, cnt_steer;
`endif

    piezo_alert_arb #(.fast_sim(1'b1), .REPEAT_CYC(RPT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PIEZO_ARB_STATS_EN
        ,
        .cnt_fast  (cnt_fast),
        .cnt_batt  (cnt_batt),
        .cnt_steer (cnt_steer)
`endif
    );

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Model: 0 = waiting, 1 = tune in progress, 2 = waiting for the player to stop.
    int m_mode, m_sel, m_load_edge;
    bit m_start, m_abort, m_active, m_loaded;

    // Player model state
    int pl_rem, pl_hold, done_cyc;
    bit pl_ab;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_start = 0; m_abort = 0; m_active = 0;
        m_loaded = 0; m_load_edge = 0;
    endtask

    // Predict outputs after the coming edge from the inputs currently driven.
    task automatic model_edge();
        int e;
        bit interval_over;
        e = edge_n + 1;
        interval_over = !m_loaded || (e - m_load_edge > K);
        m_start = 0;
        m_abort = 0;
        if (m_mode == 0) begin
            if (bus.too_fast) begin
                m_start = 1; m_sel = 3; m_mode = 1; m_active = 1;
            end else if (interval_over && (bus.batt_low || bus.en_steer)) begin
                m_start = 1; m_sel = bus.batt_low ? 2 : 1; m_mode = 1; m_active = 1;
                m_loaded = 1; m_load_edge = e;
            end
        end else if (m_mode == 1) begin
            if (bus.tune_done) begin
                m_mode = 0; m_sel = 0; m_active = 0;
            end else if (bus.too_fast && m_sel != 3) begin
                m_abort = 1; m_mode = 2;
            end
        end else begin
            if (!bus.tune_busy) begin
                m_mode = 0; m_sel = 0; m_active = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        edge_n++;
        #1;
        chk("start", bus.tune_start, m_start);
        chk("abort", bus.tune_abort, m_abort);
        chk("sel", bus.tune_sel, m_sel);
        chk("active", bus.active, m_active);
        chk("start_abort_excl", bus.tune_start && bus.tune_abort, 0);
    endtask

    task automatic pl_reset();
        bus.tune_busy = 0; bus.tune_done = 0;
        pl_rem = 0; pl_hold = 0; pl_ab = 0;
    endtask

    // Player reacting to this cycle's outputs; drives busy/done for the next edge.
    task automatic pl_step();
        bus.tune_done = 0;
        if (bus.tune_start) begin
            bus.tune_busy = 1; pl_rem = $urandom_range(1, 6); pl_ab = 0;
        end else if (bus.tune_abort) begin
            pl_ab = 1; pl_hold = $urandom_range(0, 3);
        end else if (pl_ab) begin
            bus.tune_done = ($urandom_range(0, 3) == 0);  // stray done, must be ignored
            if (pl_hold == 0) begin
                bus.tune_busy = 0; pl_ab = 0;
            end else pl_hold--;
        end else if (bus.tune_busy) begin
            if (pl_rem == 0) begin
                bus.tune_done = 1; bus.tune_busy = 0; done_cyc = edge_n;
            end else pl_rem--;
        end
    endtask

    task automatic wait_start(input string tag, input int budget, output int s);
        s = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            pl_step();
            if (bus.tune_start) begin
                s = edge_n;
                break;
            end
        end
        chk({tag, "_seen"}, (s >= 0), 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.too_fast = 0; bus.batt_low = 0; bus.en_steer = 0;
        pl_reset();
        model_reset();
        @(posedge clk);
        edge_n++;
        #1;
        chk("rst_start", bus.tune_start, 0);
        chk("rst_abort", bus.tune_abort, 0);
        chk("rst_sel", bus.tune_sel, TUNE_NONE);
        chk("rst_active", bus.active, 0);
        rst_n = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, s, nb, no;
        bus.too_fast = 0; bus.batt_low = 0; bus.en_steer = 0;
        pl_reset();
        done_cyc = 0;

        // Steer held: immediate start, then one start per interval.
        do_reset();
        bus.en_steer = 1;
        tick();
        chk("t2_first_start", bus.tune_start, 1);
        chk("t2_first_sel", bus.tune_sel, TUNE_STEER);
        s1 = edge_n;
        pl_step();
        wait_start("t2_second", 40, s2);
        chk("t2_interval", s2 - s1, K + 1);

        // Battery and steer together: only battery, once per interval.
        do_reset();
        bus.batt_low = 1; bus.en_steer = 1;
        nb = 0; no = 0;
        for (int i = 0; i < 3 * (K + 1); i++) begin
            tick();
            pl_step();
            if (bus.tune_start) begin
                if (bus.tune_sel == TUNE_BATT) nb++; else no++;
            end
        end
        chk("t3_batt_starts", nb, 3);
        chk("t3_other_starts", no, 0);
`ifdef PIEZO_ARB_STATS_EN
        chk("t3_cnt_steer", cnt_steer, 0);
        chk("t3_cnt_batt", cnt_batt, 3);
`endif

        // too_fast preempts a battery tune; interval is not reloaded by the fast tune.
        do_reset();
        bus.batt_low = 1;
        tick();
        chk("t4_batt_start", bus.tune_sel, TUNE_BATT);
        s1 = edge_n;
        bus.tune_busy = 1; tick();
        bus.too_fast = 1; tick();
        chk("t4_abort", bus.tune_abort, 1);
        tick();
        chk("t4_abort_hold", bus.active, 1);
        bus.tune_busy = 0; tick();
        chk("t4_idle", bus.active, 0);
        tick();
        chk("t4_fast_start", bus.tune_start, 1);
        chk("t4_fast_sel", bus.tune_sel, TUNE_FAST);
        bus.too_fast = 0; bus.tune_busy = 1; tick();
        bus.tune_busy = 0; bus.tune_done = 1; tick();
        bus.tune_done = 0;
        wait_start("t4_batt_again", 40, s);
        chk("t4_timer_untouched", s - s1, K + 1);

        // Continuous too_fast: back-to-back fast tunes, two cycles after each done.
        do_reset();
        bus.too_fast = 1;
        wait_start("t5_first", 5, s);
        for (int i = 1; i < 5; i++) begin
            wait_start("t5_next", 20, s);
            chk("t5_gap", s - done_cyc, 2);
            chk("t5_sel", bus.tune_sel, TUNE_FAST);
        end

        // done and too_fast in the same cycle: no abort.
        do_reset();
        bus.en_steer = 1;
        tick();
        bus.en_steer = 0; bus.tune_busy = 1;
        tick(); tick();
        bus.tune_busy = 0; bus.tune_done = 1; bus.too_fast = 1;
        tick();
        chk("t6_no_abort", bus.tune_abort, 0);
        chk("t6_idle", bus.active, 0);
        bus.tune_done = 0;
        tick();
        chk("t6_fast_start", bus.tune_start, 1);
        chk("t6_fast_sel", bus.tune_sel, TUNE_FAST);

        // Asynchronous reset mid-tune clears outputs and the interval.
        do_reset();
        bus.en_steer = 1;
        tick();
        bus.tune_busy = 1;
        tick(); tick();
        #2;
        rst_n = 0;
        #1;
        chk("t7_async_active", bus.active, 0);
        chk("t7_async_sel", bus.tune_sel, TUNE_NONE);
        chk("t7_async_start", bus.tune_start, 0);
        model_reset();
        pl_reset();
        @(posedge clk);
        edge_n++;
        #1;
        rst_n = 1;
        tick();
        chk("t7_restart", bus.tune_start, 1);
        chk("t7_restart_sel", bus.tune_sel, TUNE_STEER);
        pl_step();

        // Randomized alerts with a randomized player.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) bus.too_fast = ~bus.too_fast;
            if ($urandom_range(0, 14) == 0) bus.batt_low = ~bus.batt_low;
            if ($urandom_range(0, 9) == 0)  bus.en_steer = ~bus.en_steer;
            tick();
            pl_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
